// File: rtl/database_arbiter.sv
// database_arbiter: shares one classifier database streamer among
// NUM_REQ I2LBS engines with round-robin grants.
// Ports:
//   clk, reset (async, active-high)
//   i_request[NUM_REQ]  per-engine request (level, held until served)
//   i_load_done         database first stage loaded; gates new grants
//   i_end_database      last entry of the current stream
//   o_grant[NUM_REQ]    one-hot grant, zero when idle
//   o_grant_index       binary grantee index, held when idle
//   o_enable            database enable (STREAM only)
//   o_reset_database    index-counter reset pulse between grants
//   o_busy              high outside IDLE
module database_arbiter #(
    parameter int NUM_REQ    = 5,
    parameter int IDX_WIDTH  = 3,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   i_request,
    input  logic                 i_load_done,
    input  logic                 i_end_database,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic [IDX_WIDTH-1:0] o_grant_index,
    output logic                 o_enable,
    output logic                 o_reset_database,
    output logic                 o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        RELEASE
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [IDX_WIDTH-1:0] rr_ptr;
    logic [IDX_WIDTH-1:0] rr_ptr_nx;
    logic [3:0]           gap_cnt;
    logic [3:0]           gap_cnt_nx;
    logic [NUM_REQ-1:0]   grant_nx;
    logic [IDX_WIDTH-1:0] index_nx;
    logic                 enable_nx;
    logic                 rst_db_nx;
    logic                 busy_nx;
    logic                 found;
    logic [IDX_WIDTH-1:0] winner;
    logic                 stream_done;

    // Round-robin pick: lowest requester above rr_ptr first,
    // otherwise wrap to the lowest requester overall.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && i_request[j] && (IDX_WIDTH'(j) > rr_ptr)) begin
                found  = 1'b1;
                winner = IDX_WIDTH'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && i_request[j]) begin
                found  = 1'b1;
                winner = IDX_WIDTH'(j);
            end
        end
    end

    // Grant is one-hot, so masking detects the grantee dropping out.
    assign stream_done = i_end_database || ((o_grant & i_request) == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            rr_ptr           <= IDX_WIDTH'(NUM_REQ - 1);
            gap_cnt          <= '0;
            o_grant          <= '0;
            o_grant_index    <= '0;
            o_enable         <= 1'b0;
            o_reset_database <= 1'b0;
            o_busy           <= 1'b0;
        end else begin
            state            <= state_nx;
            rr_ptr           <= rr_ptr_nx;
            gap_cnt          <= gap_cnt_nx;
            o_grant          <= grant_nx;
            o_grant_index    <= index_nx;
            o_enable         <= enable_nx;
            o_reset_database <= rst_db_nx;
            o_busy           <= busy_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        gap_cnt_nx = gap_cnt;
        unique case (state)
            IDLE: begin
                if (i_load_done && found) begin
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                if (stream_done) begin
                    state_nx   = RELEASE;
                    gap_cnt_nx = 4'(GAP_CYCLES - 1);
                end
            end
            RELEASE: begin
                if (gap_cnt == '0) begin
                    state_nx = IDLE;
                end else begin
                    gap_cnt_nx = gap_cnt - 4'd1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        grant_nx  = o_grant;
        index_nx  = o_grant_index;
        rr_ptr_nx = rr_ptr;
        enable_nx = o_enable;
        rst_db_nx = o_reset_database;
        busy_nx   = o_busy;
        unique case (state)
            IDLE: begin
                if (state_nx == STREAM) begin
                    grant_nx         = '0;
                    grant_nx[winner] = 1'b1;
                    index_nx         = winner;
                    rr_ptr_nx        = winner;
                    enable_nx        = 1'b1;
                    rst_db_nx        = 1'b0;
                    busy_nx          = 1'b1;
                end
            end
            STREAM: begin
                if (state_nx == RELEASE) begin
                    grant_nx  = '0;
                    enable_nx = 1'b0;
                    rst_db_nx = 1'b1;
                end
            end
            RELEASE: begin
                if (state_nx == IDLE) begin
                    rst_db_nx = 1'b0;
                    busy_nx   = 1'b0;
                end
            end
            default: begin
                grant_nx  = '0;
                enable_nx = 1'b0;
                rst_db_nx = 1'b0;
                busy_nx   = 1'b0;
            end
        endcase
    end

endmodule
